spi_cmd_sequencer: RTL and testbench
====================================

# spi_cmd_sequencer

Command sequencer that sits directly upstream of the SPI master and drives its `start`, `master_rd_wr`, `master_address` and `master_out_data` inputs. It accepts read/write commands through a valid/ready FIFO and runs one SPI frame per command. It detects frame completion from the master's chip-select and returns read data (or a timeout error) through a response FIFO. This lets software-side logic queue transactions without tracking the master's 19-cycle frame timing.

## Interface
- `DEPTH`, 4, command FIFO entries (power of 2, ≥2)
- `RSP_DEPTH`, 4, response FIFO entries (power of 2, ≥2)
- `TIMEOUT`, 32, max cycles in LAUNCH or XFER before abort (≥24)
- `GAP`, 2, idle cycles with `start`=0 between frames (≥2)

- `mclk` in 1: single clock, same as SPI master
- `reset` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: command FIFO not full
- `cmd_rd_wr` in 1: 1=read, 0=write
- `cmd_addr` in 7: target address
- `cmd_wdata` in 8: write data (ignored for reads)
- `rsp_valid` out 1: response FIFO not empty
- `rsp_ready` in 1: response consumed
- `rsp_data` out 8: read data (0 on error)
- `rsp_addr` out 7: address of the completed command
- `rsp_err` out 1: 1 = frame timed out
- `start` out 1: to master, held for the whole frame
- `master_rd_wr` out 1: to master
- `master_address` out 7: to master
- `master_out_data` out 8: to master
- `master_in_data` in 8: from master, read result
- `master_cs` in 1: master chip-select, active-low, synchronous to `mclk`
- `busy` out 1: FSM not in IDLE or command FIFO non-empty

## Operation
- Command FIFO: push on `cmd_valid && cmd_ready`. `cmd_ready = !full`. Simultaneous push and pop when full is not allowed (`cmd_ready` is 0). Simultaneous push and pop otherwise leaves the count unchanged. Pointers wrap modulo DEPTH.
- Response FIFO: pop on `rsp_valid && rsp_ready`. Head fields drive `rsp_*` directly.
- `cs_q` = `master_cs` registered. cs-fall = `cs_q && !master_cs`. cs-rise = `!cs_q && master_cs`.
- FSM states:
  - IDLE: if the command FIFO is non-empty and the response FIFO is not full, then:
    - pop the head
    - load `master_rd_wr`, `master_address`, `master_out_data` (`master_out_data` = 0 for reads)
    - set `start`=1, clear the timer, go to LAUNCH
  - LAUNCH: on cs-fall, clear the timer and go to XFER. If the timer reaches TIMEOUT, go to ABORT.
  - XFER: on cs-rise, set `start`=0 and go to CAPTURE. If the timer reaches TIMEOUT, go to ABORT.
  - CAPTURE (1 cycle): sample `master_in_data`.
    - Read: push {data, addr, err=0}.
    - Write: push nothing.
    - Go to WAIT.
  - ABORT (1 cycle): set `start`=0. Push {0, addr, err=1} for both reads and writes. Go to WAIT.
  - WAIT: hold `start`=0 for GAP cycles, then go to IDLE.
- Response push never overflows: launch is gated on a free response slot, and only one frame is in flight.
- `master_*` operand outputs are held stable from LAUNCH until the next launch.
- Reset (asynchronous, any state, including mid-frame):
  - `start`=0, `master_rd_wr`=0, `master_address`=0, `master_out_data`=0
  - `cs_q`=1, FSM=IDLE, timer=0
  - both FIFOs emptied, so `rsp_valid`=0, `rsp_data`/`rsp_addr`/`rsp_err`=0
  - `busy`=0, `cmd_ready`=1
  - An in-flight frame is dropped with no response.

## Timing
- Command accepted at edge N into an empty FIFO with FSM in IDLE: pop and `start`=1 at edge N+1.
- The master asserts cs low 2 edges after it first samples `start`. It deasserts cs at its count 18.
- cs-rise is detected 1 edge after `master_cs` goes high. `master_in_data` is sampled at the following edge (CAPTURE), 1 cycle after the master updates it.
- For reads, `rsp_valid` rises 1 cycle after CAPTURE.
- Frame-to-frame spacing is ≥ GAP+1 cycles with `start`=0, which guarantees the master's counter resets.
- The timer counts every cycle in LAUNCH and XFER. ABORT is entered at the edge where timer == TIMEOUT-1.

## Test plan
- Write: cmd {wr, 0x15, 0xA5}.
  - `master_rd_wr`=0, `master_address`=0x15, `master_out_data`=0xA5 held while `start`=1.
  - `start` drops 1 cycle after cs-rise.
  - No response; `busy`=0 after GAP.
- Read: cmd {rd, 0x2B}, slave returns 0x3C.
  - One response {data=0x3C, addr=0x2B, err=0}.
  - `rsp_valid` stays high until `rsp_ready`.
- Command back-pressure: `rsp_ready`=1, 6 back-to-back writes with DEPTH=4.
  - `cmd_ready` goes 0 once 4 are queued behind the active frame.
  - All 6 frames complete in order with ≥GAP idle cycles between them.
- Response back-pressure: `rsp_ready`=0, 5 reads.
  - 4 frames run, then the FSM stays in IDLE with 1 queued.
  - One `rsp_ready` pulse launches the 5th read.
- Timeout: tie `master_cs`=1 and issue a read to 0x07.
  - After 32 cycles in LAUNCH: `start`=0 and response {0x00, 0x07, err=1}.
  - The next command runs normally.
- Mid-frame reset: pulse `reset` low during XFER.
  - Immediately: `start`=0 and all outputs at reset values.
  - FIFOs empty and no response produced.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// Command sequencer in front of the SPI master: queues read/write commands, runs
// one SPI frame per command and returns read data or a timeout error.
module spi_cmd_sequencer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 32,
    parameter int unsigned GAP       = 2
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd_wr,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [6:0] rsp_addr,
    output logic       rsp_err,
    output logic       start,
    output logic       master_rd_wr,
    output logic [6:0] master_address,
    output logic [7:0] master_out_data,
    input  logic [7:0] master_in_data,
    input  logic       master_cs,
    output logic       busy
);

    localparam int unsigned CAW  = $clog2(DEPTH);
    localparam int unsigned RAW  = $clog2(RSP_DEPTH);
    localparam int unsigned TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int unsigned TW   = $clog2(TMAX);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_XFER    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_ABORT   = 3'd4;
    localparam logic [2:0] ST_WAIT    = 3'd5;

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic          cs_q;
    logic          cs_fall;
    logic          cs_rise;
    logic          timer_expired;
    logic          gap_done;
    logic          launch;

    // Command FIFO: entry = {rd_wr, addr[6:0], wdata[7:0]}
    logic [15:0]    cmd_mem [DEPTH];
    logic [CAW-1:0] cmd_wr_ptr;
    logic [CAW-1:0] cmd_rd_ptr;
    logic [CAW:0]   cmd_count;
    logic           cmd_empty;
    logic           cmd_full;
    logic           cmd_push;
    logic           cmd_pop;
    logic [15:0]    cmd_head;

    // Response FIFO: entry = {data[7:0], addr[6:0], err}
    logic [15:0]    rsp_mem [RSP_DEPTH];
    logic [RAW-1:0] rsp_wr_ptr;
    logic [RAW-1:0] rsp_rd_ptr;
    logic [RAW:0]   rsp_count;
    logic           rsp_full;
    logic           rsp_push;
    logic           rsp_pop;
    logic [15:0]    rsp_word;

    assign cmd_empty = (cmd_count == '0);
    assign cmd_full  = (cmd_count == (CAW+1)'(DEPTH));
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_head  = cmd_mem[cmd_rd_ptr];

    assign rsp_full  = (rsp_count == (RAW+1)'(RSP_DEPTH));
    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign {rsp_data, rsp_addr, rsp_err} = rsp_mem[rsp_rd_ptr];

    assign cs_fall       = cs_q && !master_cs;
    assign cs_rise       = !cs_q && master_cs;
    assign timer_expired = (timer == TW'(TIMEOUT - 1));
    assign gap_done      = (timer == TW'(GAP - 1));

    // Launching only with a free response slot keeps the response push overflow-free.
    assign launch  = (state == ST_IDLE) && !cmd_empty && !rsp_full;
    assign cmd_pop = launch;
    assign busy    = (state != ST_IDLE) || !cmd_empty;

    always_comb begin
        rsp_push = 1'b0;
        rsp_word = {master_in_data, master_address, 1'b0};
        if (state == ST_CAPTURE && master_rd_wr) begin
            rsp_push = 1'b1;
        end else if (state == ST_ABORT) begin
            rsp_push = 1'b1;
            rsp_word = {8'h00, master_address, 1'b1};
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            cs_q <= 1'b1;
        end else begin
            cs_q <= master_cs;
        end
    end

    always_ff @(posedge mclk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr] <= {cmd_rd_wr, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            end
            if (cmd_pop) begin
                cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            end
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count <= cmd_count + 1'b1;
                2'b01:   cmd_count <= cmd_count - 1'b1;
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    // Storage is cleared too so the rsp_* fields read zero straight out of reset.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                rsp_mem[i] <= '0;
            end
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (rsp_push) begin
                rsp_mem[rsp_wr_ptr] <= rsp_word;
                rsp_wr_ptr          <= rsp_wr_ptr + 1'b1;
            end
            if (rsp_pop) begin
                rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            end
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count <= rsp_count + 1'b1;
                2'b01:   rsp_count <= rsp_count - 1'b1;
                default: rsp_count <= rsp_count;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            timer           <= '0;
            start           <= 1'b0;
            master_rd_wr    <= 1'b0;
            master_address  <= '0;
            master_out_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        master_rd_wr    <= cmd_head[15];
                        master_address  <= cmd_head[14:8];
                        master_out_data <= cmd_head[15] ? 8'h00 : cmd_head[7:0];
                        start           <= 1'b1;
                        timer           <= '0;
                        state           <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (cs_fall) begin
                        timer <= '0;
                        state <= ST_XFER;
                    end else if (timer_expired) begin
                        start <= 1'b0;
                        state <= ST_ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (cs_rise) begin
                        start <= 1'b0;
                        state <= ST_CAPTURE;
                    end else if (timer_expired) begin
                        start <= 1'b0;
                        state <= ST_ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_ABORT: begin
                    start <= 1'b0;
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (gap_done) begin
                        timer <= '0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    start <= 1'b0;
                    timer <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer with a behavioural SPI master/slave
// and a queue-based reference model of commands, frames and responses.
module tb_spi_cmd_sequencer;

    localparam int DEPTH     = 4;
    localparam int RSP_DEPTH = 4;
    localparam int TIMEOUT   = 32;
    localparam int GAP       = 2;

    logic       mclk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_rd_wr;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic [6:0] rsp_addr;
    logic       rsp_err;
    logic       start, master_rd_wr;
    logic [6:0] master_address;
    logic [7:0] master_out_data;
    logic [7:0] master_in_data = 8'h00;
    logic       master_cs;
    logic       busy;

    spi_cmd_sequencer #(
        .DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)
    ) dut (
        .mclk(mclk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .start(start), .master_rd_wr(master_rd_wr), .master_address(master_address),
        .master_out_data(master_out_data), .master_in_data(master_in_data),
        .master_cs(master_cs), .busy(busy)
    );

    always #5 mclk = ~mclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: slave memory image plus expected frames and responses, in order.
    logic [7:0]  ref_mem   [128];
    logic [7:0]  slave_mem [128];
    logic [15:0] exp_frm [$];
    logic [15:0] exp_rsp [$];

    // Behavioural SPI master with attached slave memory.
    logic [4:0] m_cnt  = '0;
    logic       cs_int = 1'b1;
    bit         cs_tie = 1'b0;
    assign master_cs = cs_tie | cs_int;

    always @(posedge mclk) begin
        if (!start) begin
            m_cnt  <= '0;
            cs_int <= 1'b1;
        end else begin
            if (m_cnt != 5'd31) m_cnt <= m_cnt + 5'd1;
            if (m_cnt == 5'd2) cs_int <= 1'b0;
            if (m_cnt == 5'd18) begin
                cs_int <= 1'b1;
                if (!cs_tie) begin
                    if (master_rd_wr) master_in_data <= slave_mem[master_address];
                    else slave_mem[master_address] <= master_out_data;
                end
            end
        end
    end

    // Response checker: every pop must match the head of the expected queue.
    always @(negedge mclk) begin
        #1;
        if (reset && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) chk("rsp_spurious", 16'(exp_rsp.size()), 16'd1);
            else chk("rsp", {rsp_data, rsp_addr, rsp_err}, exp_rsp.pop_front());
        end
    end

    // Frame monitor: operands at cs-fall, stability, start drop timing, inter-frame gap.
    int unsigned frame_cnt = 0, gap = 0, start_len = 0, last_start_len = 0;
    bit          had_frame = 1'b0, prev_start = 1'b0, cs_s1 = 1'b1, cs_s2 = 1'b1;
    logic [15:0] snap_ops = '0;

    always @(negedge mclk) begin
        #1;
        if (!reset) begin
            prev_start = 1'b0;
            cs_s1      = 1'b1;
            cs_s2      = 1'b1;
            start_len  = 0;
        end else begin
            if (cs_s1 && !master_cs && start) begin
                frame_cnt++;
                snap_ops = {master_rd_wr, master_address, master_out_data};
                if (exp_frm.size() == 0) chk("frame_spurious", 16'(exp_frm.size()), 16'd1);
                else chk("frame_ops", snap_ops, exp_frm.pop_front());
            end
            if (start && !prev_start) begin
                if (had_frame) chk("gap_min", 16'(gap >= GAP + 1), 16'd1);
                start_len = 0;
            end
            if (start) start_len++;
            if (!start && prev_start) begin
                had_frame      = 1'b1;
                gap            = 1;
                last_start_len = start_len;
                if (!cs_tie) begin
                    chk("start_drop", {cs_s2, cs_s1}, 16'b01);
                    chk("ops_stable", {master_rd_wr, master_address, master_out_data}, snap_ops);
                end
            end else if (!start) begin
                gap++;
            end
            cs_s2      = cs_s1;
            cs_s1      = master_cs;
            prev_start = start;
        end
    end

    bit rand_ready = 1'b0;
    bit saw_full   = 1'b0;

    task automatic send_cmd(input logic rd, input logic [6:0] addr, input logic [7:0] wd,
                            input bit tmo);
        int unsigned waited = 0;
        @(negedge mclk);
        cmd_valid = 1'b1;
        cmd_rd_wr = rd;
        cmd_addr  = addr;
        cmd_wdata = wd;
        #1;
        while (!cmd_ready && waited < 500) begin
            saw_full = 1'b1;
            @(negedge mclk);
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
            #1;
            waited++;
        end
        chk("cmd_ready_wait", cmd_ready, 16'd1);
        if (cmd_ready) begin
            @(posedge mclk);
            if (tmo) begin
                exp_rsp.push_back({8'h00, addr, 1'b1});
            end else begin
                exp_frm.push_back({rd, addr, rd ? 8'h00 : wd});
                if (rd) exp_rsp.push_back({ref_mem[addr], addr, 1'b0});
                else ref_mem[addr] = wd;
            end
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned limit);
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge mclk);
            #1;
            if (!busy) break;
        end
        chk("idle", busy, 16'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, start, 16'd0);
        chk({tag, "_ops"}, {master_rd_wr, master_address, master_out_data}, 16'h0000);
        chk({tag, "_rsp_valid"}, rsp_valid, 16'd0);
        chk({tag, "_rsp_fields"}, {rsp_data, rsp_addr, rsp_err}, 16'h0000);
        chk({tag, "_busy"}, busy, 16'd0);
        chk({tag, "_cmd_ready"}, cmd_ready, 16'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_rd_wr = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i]   = 8'($urandom);
            slave_mem[i] = ref_mem[i];
        end

        // Reset values
        repeat (3) @(negedge mclk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b1;

        // Write: operands loaded one edge after acceptance, no response
        send_cmd(1'b0, 7'h15, 8'hA5, 1'b0);
        @(negedge mclk); #1;
        chk("wr_start_n", start, 16'd0);
        chk("wr_busy_queued", busy, 16'd1);
        @(negedge mclk); #1;
        chk("wr_start_n1", start, 16'd1);
        chk("wr_ops", {master_rd_wr, master_address, master_out_data}, {1'b0, 7'h15, 8'hA5});
        wait_idle(100);
        chk("wr_no_rsp", rsp_valid, 16'd0);
        chk("wr_slave_mem", slave_mem[7'h15], 16'hA5);

        // Read: response held until consumed
        rsp_ready = 1'b0;
        ref_mem[7'h2B]   = 8'h3C;
        slave_mem[7'h2B] = 8'h3C;
        send_cmd(1'b1, 7'h2B, 8'hFF, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge mclk); #1;
            if (rsp_valid) break;
        end
        repeat (5) @(negedge mclk);
        #1;
        chk("rd_valid_held", rsp_valid, 16'd1);
        chk("rd_fields", {rsp_data, rsp_addr, rsp_err}, {8'h3C, 7'h2B, 1'b0});
        @(negedge mclk); rsp_ready = 1'b1;
        @(negedge mclk); rsp_ready = 1'b0;
        #1;
        chk("rd_popped", rsp_valid, 16'd0);
        wait_idle(100);

        // Command back-pressure: six back-to-back writes
        rsp_ready = 1'b1;
        saw_full  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_cmd(1'b0, 7'(8'h40 + i), 8'($urandom), 1'b0);
        end
        chk("cmd_full_seen", saw_full, 16'd1);
        wait_idle(400);
        chk("bp_frames_done", 16'(exp_frm.size()), 16'd0);

        // Response back-pressure: five reads, only four can run
        rsp_ready = 1'b0;
        base = frame_cnt;
        for (int i = 0; i < 5; i++) begin
            send_cmd(1'b1, 7'($urandom_range(0, 127)), 8'h00, 1'b0);
        end
        repeat (160) @(negedge mclk);
        #1;
        chk("rbp_frames4", 16'(frame_cnt - base), 16'd4);
        chk("rbp_busy", busy, 16'd1);
        chk("rbp_start_low", start, 16'd0);
        chk("rbp_rsp_valid", rsp_valid, 16'd1);
        @(negedge mclk); rsp_ready = 1'b1;
        @(negedge mclk); rsp_ready = 1'b0;
        repeat (40) @(negedge mclk);
        #1;
        chk("rbp_frames5", 16'(frame_cnt - base), 16'd5);
        rsp_ready = 1'b1;
        wait_idle(100);
        repeat (6) @(negedge mclk);
        #1;
        chk("rbp_drained", 16'(exp_rsp.size()), 16'd0);

        // Timeout: chip-select never falls
        cs_tie = 1'b1;
        send_cmd(1'b1, 7'h07, 8'h00, 1'b1);
        wait_idle(200);
        chk("tmo_start_len", 16'(last_start_len), 16'(TIMEOUT));
        repeat (3) @(negedge mclk);
        #1;
        chk("tmo_rsp_done", 16'(exp_rsp.size()), 16'd0);
        cs_tie = 1'b0;
        send_cmd(1'b1, 7'h07, 8'h00, 1'b0);
        wait_idle(100);
        repeat (3) @(negedge mclk);
        #1;
        chk("post_tmo_rsp", 16'(exp_rsp.size()), 16'd0);

        // Randomized traffic with random response back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            send_cmd(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom), 1'b0);
        end
        rand_ready = 1'b0;
        rsp_ready  = 1'b1;
        wait_idle(1000);
        repeat (6) @(negedge mclk);
        #1;
        chk("rand_rsp_drained", 16'(exp_rsp.size()), 16'd0);
        chk("rand_frm_drained", 16'(exp_frm.size()), 16'd0);

        // Mid-frame reset: in-flight and queued reads are dropped
        for (int i = 0; i < 3; i++) begin
            send_cmd(1'b1, 7'(8'h10 + i), 8'h00, 1'b0);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge mclk); #1;
            if (!master_cs) break;
        end
        chk("rst_in_xfer", master_cs, 16'd0);
        repeat (3) @(negedge mclk);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_frm.delete();
        exp_rsp.delete();
        base = frame_cnt;
        repeat (2) @(negedge mclk);
        #3;
        reset = 1'b1;
        repeat (30) @(negedge mclk);
        #1;
        chk("midrst_no_rsp", rsp_valid, 16'd0);
        chk("midrst_idle", busy, 16'd0);
        chk("midrst_no_frame", 16'(frame_cnt - base), 16'd0);
        send_cmd(1'b1, 7'h2B, 8'h00, 1'b0);
        wait_idle(100);
        repeat (3) @(negedge mclk);
        #1;
        chk("midrst_recover", 16'(exp_rsp.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
